// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// FSM state codes and register-number width.
package hazard_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_EX  = 2'b01,
      FWD_MEM = 2'b10,
      FWD_WB  = 2'b11
   } fwd_e;

   localparam logic [0:0] ST_RUN      = 1'b0;
   localparam logic [0:0] ST_MEM_WAIT = 1'b1;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: pipeline-side sources and the controller's enables,
// bubbles and forwarding selects. master = pipeline, slave = controller.
interface pipeline_hazard_ctrl_if;
   import hazard_pkg::*;

   logic [REG_W-1:0] id_ra, id_rb, ex_rd, mem_rd, wb_rd;
   logic             id_ra_use, id_rb_use;
   logic             ex_rf_le, ex_load, ex_branch;
   logic             mem_rf_le, mem_req, mem_ready;
   logic             wb_rf_le;

   logic             pc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le;
   logic             id_ex_bubble, if_id_flush, mem_wb_bubble;
   logic [1:0]       fwd_a, fwd_b;
   logic             mem_timeout;

   modport master (
      output id_ra, id_rb, id_ra_use, id_rb_use, ex_rd, ex_rf_le, ex_load, ex_branch,
             mem_rd, mem_rf_le, mem_req, mem_ready, wb_rd, wb_rf_le,
      input  pc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le,
             id_ex_bubble, if_id_flush, mem_wb_bubble, fwd_a, fwd_b, mem_timeout
   );

   modport slave (
      input  id_ra, id_rb, id_ra_use, id_rb_use, ex_rd, ex_rf_le, ex_load, ex_branch,
             mem_rd, mem_rf_le, mem_req, mem_ready, wb_rd, wb_rf_le,
      output pc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le,
             id_ex_bubble, if_id_flush, mem_wb_bubble, fwd_a, fwd_b, mem_timeout
   );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one ID operand: youngest matching producer wins,
// EX is skipped for loads because the load-use stall covers that case.
module hazard_fwd_sel
   import hazard_pkg::*;
(
   input  logic [REG_W-1:0] src,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_rf_le,
   input  logic             ex_load,
   input  logic [REG_W-1:0] mem_rd,
   input  logic             mem_rf_le,
   input  logic [REG_W-1:0] wb_rd,
   input  logic             wb_rf_le,
   output fwd_e             sel
);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      sel = FWD_RF;
      if (src != '0) begin
         if (ex_rf_le && !ex_load && ex_rd == src)
            sel = FWD_EX;
         else if (mem_rf_le && mem_rd == src)
            sel = FWD_MEM;
         else if (wb_rf_le && wb_rd == src)
            sel = FWD_WB;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory freeze FSM, branch squash, load-use stall
// and operand forwarding. Define HAZ_STATS_EN to add saturating event counters.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int WAIT_MAX = 16,
   parameter int CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   pipeline_hazard_ctrl_if.slave hz
`ifdef HAZ_STATS_EN
   ,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt,
   output logic [CNT_W-1:0]     wait_cnt
`endif
);

   localparam int WCNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

   logic [0:0]        state;
   logic [WCNT_W-1:0] wait_q;
   logic              timeout_q;
   logic              wait_expire, freeze, branch, ra_hit, rb_hit, load_use;
   fwd_e              fwd_a_sel, fwd_b_sel;

   assign wait_expire = (state == ST_MEM_WAIT) && !hz.mem_ready &&
                        (wait_q == WCNT_W'(WAIT_MAX - 1));

   assign freeze = !reset &&
                   (((state == ST_RUN) && hz.mem_req && !hz.mem_ready) ||
                    ((state == ST_MEM_WAIT) && !hz.mem_ready && !wait_expire));

   assign branch = !reset && !freeze && hz.ex_branch;

   assign ra_hit   = hz.id_ra_use && (hz.id_ra == hz.ex_rd);
   assign rb_hit   = hz.id_rb_use && (hz.id_rb == hz.ex_rd);
   assign load_use = !reset && !freeze && !hz.ex_branch &&
                     hz.ex_load && hz.ex_rf_le && (hz.ex_rd != '0) && (ra_hit || rb_hit);

   hazard_fwd_sel u_fwd_a (
      .src(hz.id_ra), .ex_rd(hz.ex_rd), .ex_rf_le(hz.ex_rf_le), .ex_load(hz.ex_load),
      .mem_rd(hz.mem_rd), .mem_rf_le(hz.mem_rf_le), .wb_rd(hz.wb_rd), .wb_rf_le(hz.wb_rf_le),
      .sel(fwd_a_sel)
   );

   hazard_fwd_sel u_fwd_b (
      .src(hz.id_rb), .ex_rd(hz.ex_rd), .ex_rf_le(hz.ex_rf_le), .ex_load(hz.ex_load),
      .mem_rd(hz.mem_rd), .mem_rf_le(hz.mem_rf_le), .wb_rd(hz.wb_rd), .wb_rf_le(hz.wb_rf_le),
      .sel(fwd_b_sel)
   );

   always_comb begin
      hz.pc_le         = 1'b1;
      hz.if_id_le      = 1'b1;
      hz.id_ex_le      = 1'b1;
      hz.ex_mem_le     = 1'b1;
      hz.mem_wb_le     = 1'b1;
      hz.id_ex_bubble  = 1'b0;
      hz.if_id_flush   = 1'b0;
      hz.mem_wb_bubble = 1'b0;
      if (freeze) begin
         hz.pc_le         = 1'b0;
         hz.if_id_le      = 1'b0;
         hz.id_ex_le      = 1'b0;
         hz.ex_mem_le     = 1'b0;
         hz.mem_wb_bubble = 1'b1;
      end else if (branch) begin
         hz.if_id_flush = 1'b1;
      end else if (load_use) begin
         hz.pc_le        = 1'b0;
         hz.if_id_le     = 1'b0;
         hz.id_ex_bubble = 1'b1;
      end
   end

   assign hz.fwd_a       = reset ? FWD_RF : fwd_a_sel;
   assign hz.fwd_b       = reset ? FWD_RF : fwd_b_sel;
   assign hz.mem_timeout = timeout_q;

   // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_RUN;
         wait_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               wait_q <= '0;
               if (hz.mem_req && !hz.mem_ready)
                  state <= ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
               if (hz.mem_ready) begin
                  state  <= ST_RUN;
                  wait_q <= '0;
               end else if (wait_expire) begin
                  state     <= ST_RUN;
                  wait_q    <= '0;
                  timeout_q <= 1'b1;
               end else begin
                  wait_q <= wait_q + WCNT_W'(1);
               end
            end
            default: begin
               state  <= ST_RUN;
               wait_q <= '0;
            end
         endcase
      end
   end

`ifdef HAZ_STATS_EN
   // Counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
         wait_cnt  <= '0;
      end else begin
         if (load_use && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
         if (branch && flush_cnt != '1)   flush_cnt <= flush_cnt + CNT_W'(1);
         if (freeze && wait_cnt != '1)    wait_cnt  <= wait_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: stimulus pushes expected output
// words into a queue, a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;
   import hazard_pkg::*;

   localparam int WAIT_MAX = 16;
   localparam int CNT_W    = 16;

   localparam logic [4:0] LE_ALL   = 5'b11111;
   localparam logic [4:0] LE_STALL = 5'b00111;
   localparam logic [4:0] LE_FRZ   = 5'b00001;

   typedef struct {
      string       name;
      logic [12:0] word;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   pipeline_hazard_ctrl_if hz_bus ();

`ifdef HAZ_STATS_EN
   logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;
`endif

   pipeline_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .reset(reset),
      .hz(hz_bus)
`ifdef HAZ_STATS_EN
      ,
      .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt),
      .wait_cnt(wait_cnt)
`endif
   );

   always #5 clk = ~clk;

   // {pc,if_id,id_ex,ex_mem,mem_wb LE, id_ex_bubble, if_id_flush, mem_wb_bubble, fwd_a, fwd_b, timeout}
   function automatic logic [12:0] pk(input logic [4:0] le, input logic bub, input logic fl,
                                      input logic mwb, input logic [1:0] fa, input logic [1:0] fb,
                                      input logic to);
      return {le, bub, fl, mwb, fa, fb, to};
   endfunction

   function automatic logic [12:0] actual();
      return {hz_bus.pc_le, hz_bus.if_id_le, hz_bus.id_ex_le, hz_bus.ex_mem_le, hz_bus.mem_wb_le,
              hz_bus.id_ex_bubble, hz_bus.if_id_flush, hz_bus.mem_wb_bubble,
              hz_bus.fwd_a, hz_bus.fwd_b, hz_bus.mem_timeout};
   endfunction

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         logic [12:0] got;
         e   = sb_q.pop_front();
         got = actual();
         n_cmp++;
         if (got !== e.word) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (le5 bub fl mwb fa fb to)", e.name, got, e.word);
         end
      end
   end

   task automatic idle();
      hz_bus.id_ra = '0;  hz_bus.id_rb = '0;  hz_bus.id_ra_use = 1'b0; hz_bus.id_rb_use = 1'b0;
      hz_bus.ex_rd = '0;  hz_bus.ex_rf_le = 1'b0; hz_bus.ex_load = 1'b0; hz_bus.ex_branch = 1'b0;
      hz_bus.mem_rd = '0; hz_bus.mem_rf_le = 1'b0; hz_bus.mem_req = 1'b0; hz_bus.mem_ready = 1'b0;
      hz_bus.wb_rd = '0;  hz_bus.wb_rf_le = 1'b0;
   endtask

   task automatic step(input string name, input logic [12:0] word);
      exp_t e;
      e.name = name;
      e.word = word;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   initial begin
      reset = 1'b1;
      idle();
      @(posedge clk);
      #1;

      // Reset dominates every hazard source.
      hz_bus.ex_branch = 1'b1; hz_bus.mem_req = 1'b1;
      hz_bus.ex_load = 1'b1; hz_bus.ex_rf_le = 1'b1; hz_bus.ex_rd = 5'd5;
      hz_bus.id_ra = 5'd5; hz_bus.id_ra_use = 1'b1;
      hz_bus.mem_rf_le = 1'b1; hz_bus.mem_rd = 5'd5;
      step("reset_force", pk(LE_ALL, 0, 0, 0, 2'b00, 2'b00, 0));

      reset = 1'b0;
      idle();
      step("idle", pk(LE_ALL, 0, 0, 0, 2'b00, 2'b00, 0));

      // Load-use on operand a, then the load forwarded from MEM.
      hz_bus.ex_load = 1'b1; hz_bus.ex_rf_le = 1'b1; hz_bus.ex_rd = 5'd5;
      hz_bus.id_ra = 5'd5; hz_bus.id_ra_use = 1'b1;
      step("load_use_a", pk(LE_STALL, 1, 0, 0, 2'b00, 2'b00, 0));
      idle();
      hz_bus.mem_rd = 5'd5; hz_bus.mem_rf_le = 1'b1;
      hz_bus.id_ra = 5'd5; hz_bus.id_ra_use = 1'b1;
      step("ld_fwd_mem", pk(LE_ALL, 0, 0, 0, 2'b10, 2'b00, 0));

      idle();
      hz_bus.ex_load = 1'b1; hz_bus.ex_rf_le = 1'b1; hz_bus.ex_rd = 5'd7;
      hz_bus.id_rb = 5'd7;
      step("ld_unused", pk(LE_ALL, 0, 0, 0, 2'b00, 2'b00, 0));
      idle();
      hz_bus.ex_load = 1'b1; hz_bus.ex_rf_le = 1'b1; hz_bus.ex_rd = 5'd0;
      hz_bus.id_ra_use = 1'b1;
      step("ld_r0", pk(LE_ALL, 0, 0, 0, 2'b00, 2'b00, 0));

      // Forwarding priority on operand b.
      idle();
      hz_bus.ex_rf_le = 1'b1; hz_bus.ex_rd = 5'd3;
      hz_bus.mem_rf_le = 1'b1; hz_bus.mem_rd = 5'd3;
      hz_bus.wb_rf_le = 1'b1; hz_bus.wb_rd = 5'd3;
      hz_bus.id_rb = 5'd3; hz_bus.id_rb_use = 1'b1; hz_bus.id_ra = 5'd9;
      step("fwd_ex", pk(LE_ALL, 0, 0, 0, 2'b00, 2'b01, 0));
      hz_bus.ex_rf_le = 1'b0;
      step("fwd_mem", pk(LE_ALL, 0, 0, 0, 2'b00, 2'b10, 0));
      hz_bus.mem_rf_le = 1'b0;
      step("fwd_wb", pk(LE_ALL, 0, 0, 0, 2'b00, 2'b11, 0));
      hz_bus.ex_rf_le = 1'b1; hz_bus.mem_rf_le = 1'b1;
      hz_bus.id_rb = 5'd0; hz_bus.id_ra = 5'd3;
      step("fwd_r0", pk(LE_ALL, 0, 0, 0, 2'b01, 2'b00, 0));

      // Taken branch, alone and together with a load-use pattern.
      idle();
      hz_bus.ex_branch = 1'b1;
      step("branch", pk(LE_ALL, 0, 1, 0, 2'b00, 2'b00, 0));
      hz_bus.ex_load = 1'b1; hz_bus.ex_rf_le = 1'b1; hz_bus.ex_rd = 5'd5;
      hz_bus.id_ra = 5'd5; hz_bus.id_ra_use = 1'b1;
      step("branch_ld", pk(LE_ALL, 0, 1, 0, 2'b00, 2'b00, 0));

      // Memory freeze released by ready; branch held to show freeze priority.
      idle();
      hz_bus.mem_req = 1'b1; hz_bus.ex_branch = 1'b1;
      hz_bus.wb_rf_le = 1'b1; hz_bus.wb_rd = 5'd4; hz_bus.id_ra = 5'd4;
      step("frz_entry", pk(LE_FRZ, 0, 0, 1, 2'b11, 2'b00, 0));
      for (int i = 0; i < 3; i++)
         step("frz_wait", pk(LE_FRZ, 0, 0, 1, 2'b11, 2'b00, 0));
      hz_bus.mem_ready = 1'b1;
      step("frz_release", pk(LE_ALL, 0, 1, 0, 2'b11, 2'b00, 0));
      idle();
      step("frz_after", pk(LE_ALL, 0, 0, 0, 2'b00, 2'b00, 0));

      // Memory never ready: forced release after WAIT_MAX freeze cycles.
      hz_bus.mem_req = 1'b1;
      for (int i = 0; i < WAIT_MAX; i++)
         step("to_freeze", pk(LE_FRZ, 0, 0, 1, 2'b00, 2'b00, 0));
      hz_bus.mem_req = 1'b0;
      step("to_release", pk(LE_ALL, 0, 0, 0, 2'b00, 2'b00, 0));
      step("to_sticky1", pk(LE_ALL, 0, 0, 0, 2'b00, 2'b00, 1));
      step("to_sticky2", pk(LE_ALL, 0, 0, 0, 2'b00, 2'b00, 1));

`ifdef HAZ_STATS_EN
      check("stall_cnt", stall_cnt, 16'd1);
      check("flush_cnt", flush_cnt, 16'd3);
      check("wait_cnt", wait_cnt, 16'd20);
`endif

      // Reset while in MEM_WAIT returns to RUN with the error cleared.
      hz_bus.mem_req = 1'b1;
      step("rst_frz_entry", pk(LE_FRZ, 0, 0, 1, 2'b00, 2'b00, 1));
      reset = 1'b1;
      step("rst_in_wait", pk(LE_ALL, 0, 0, 0, 2'b00, 2'b00, 1));
      reset = 1'b0;
      hz_bus.mem_req = 1'b0;
      step("rst_run", pk(LE_ALL, 0, 0, 0, 2'b00, 2'b00, 0));

`ifdef HAZ_STATS_EN
      check("stall_cnt_rst", stall_cnt, 16'd0);
      check("flush_cnt_rst", flush_cnt, 16'd0);
      check("wait_cnt_rst", wait_cnt, 16'd0);
`endif

      repeat (2) @(posedge clk);
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
